// File: rtl/e_muldiv_pkg.sv
// Shared multiply/divide definitions: op encodings, FSM states and default latencies.
// Consumed by the decoder, the hazard unit and e_muldiv.
package e_muldiv_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MADD  = 4'd7,
    MD_MADDU = 4'd8,
    MD_MSUB  = 4'd9,
    MD_MSUBU = 4'd10
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

endpackage

// File: rtl/e_muldiv_ctrl.sv
// Latency counter and busy FSM for the multiply/divide unit.
// done pulses in the last busy cycle, i.e. on the edge that commits the result.
module e_muldiv_ctrl
  import e_muldiv_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [4:0] load_cnt,
  output logic       busy,
  output logic       done
);

  md_state_e  state, state_nxt;
  logic [4:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done      = 1'b0;
    case (state)
      MD_IDLE: begin
        if (load) begin
          state_nxt = MD_RUN;
          cnt_nxt   = load_cnt;
        end
      end
      MD_RUN: begin
        if (cnt == 5'd1) begin
          done      = 1'b1;
          state_nxt = MD_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - 5'd1;
        end
      end
      default: state_nxt = MD_IDLE;
    endcase
  end

  assign busy = (state == MD_RUN);

endmodule

// File: rtl/e_muldiv.sv
// Execute-stage multiply/divide unit owning HI/LO; multi-cycle ops raise busy.
// Define MULDIV_MADD_EN to enable MADD/MADDU/MSUB/MSUBU accumulate ops.
module e_muldiv
  import e_muldiv_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [4:0] MULT_CNT = 5'(MULT_CYCLES);
  localparam logic [4:0] DIV_CNT  = 5'(DIV_CYCLES);

  logic               busy_i, done, accept, load;
  logic [3:0]         op_q;
  logic [31:0]        a_q, b_q, hi_q, lo_q;
  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic               wr_en;
  logic [63:0]        res;

  function automatic logic is_long_op(logic [3:0] o);
    case (o)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: is_long_op = 1'b1;
`ifdef MULDIV_MADD_EN
      MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: is_long_op = 1'b1;
`endif
      default: is_long_op = 1'b0;
    endcase
  endfunction

  // Returns {remainder, quotient}; the INT_MIN / -1 overflow is pinned explicitly.
  function automatic logic [63:0] div_signed(logic [31:0] a, logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = signed'(a);
    sb = signed'(b);
    if (b == '0)
      div_signed = '0;
    else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      div_signed = {32'h0000_0000, 32'h8000_0000};
    else
      div_signed = {sa % sb, sa / sb};
  endfunction

  function automatic logic [63:0] div_unsigned(logic [31:0] a, logic [31:0] b);
    if (b == '0)
      div_unsigned = '0;
    else
      div_unsigned = {a % b, a / b};
  endfunction

  assign accept = start && !busy_i;
  assign load   = accept && is_long_op(op);

  e_muldiv_ctrl u_ctrl (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_cnt ((op == MD_DIV || op == MD_DIVU) ? DIV_CNT : MULT_CNT),
    .busy     (busy_i),
    .done     (done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q <= MD_NONE;
      a_q  <= '0;
      b_q  <= '0;
    end else if (load) begin
      op_q <= op;
      a_q  <= rs_val;
      b_q  <= rt_val;
    end
  end

  assign prod_s = signed'({{32{a_q[31]}}, a_q}) * signed'({{32{b_q[31]}}, b_q});
  assign prod_u = {32'h0, a_q} * {32'h0, b_q};

  // Result is formed from latched operands and only committed on done.
  always_comb begin
    wr_en = 1'b0;
    res   = {hi_q, lo_q};
    if (done) begin
      case (op_q)
        MD_MULT:  begin wr_en = 1'b1; res = prod_s; end
        MD_MULTU: begin wr_en = 1'b1; res = prod_u; end
        MD_DIV:   begin wr_en = (b_q != '0); res = div_signed(a_q, b_q); end
        MD_DIVU:  begin wr_en = (b_q != '0); res = div_unsigned(a_q, b_q); end
`ifdef MULDIV_MADD_EN
        MD_MADD:  begin wr_en = 1'b1; res = {hi_q, lo_q} + prod_s; end
        MD_MADDU: begin wr_en = 1'b1; res = {hi_q, lo_q} + prod_u; end
        MD_MSUB:  begin wr_en = 1'b1; res = {hi_q, lo_q} - prod_s; end
        MD_MSUBU: begin wr_en = 1'b1; res = {hi_q, lo_q} - prod_u; end
`endif
        default:  wr_en = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (wr_en) begin
      {hi_q, lo_q} <= res;
    end else if (accept && op == MD_MTHI) begin
      hi_q <= rs_val;
    end else if (accept && op == MD_MTLO) begin
      lo_q <= rs_val;
    end
  end

  assign busy = busy_i;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_e_muldiv.sv
// Bench for e_muldiv: directed spec cases plus randomized ops against an arithmetic HI/LO model.
// Define MULDIV_MADD_EN to also exercise the accumulate ops.
module tb_e_muldiv;
  import e_muldiv_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk, reset, start, busy;
  logic [3:0]  op;
  logic [31:0] rs_val, rt_val, hi, lo;

  int errors = 0;
  int checks = 0;
  int ign_seen = 0;
  logic [31:0] hi_m, lo_m;

  e_muldiv #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flags a start issued while the unit is busy (hazard-unit contract breach).
  always @(posedge clk)
    if (!reset && start && busy) ign_seen++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int exp_cycles(logic [3:0] o);
    case (o)
      MD_MULT, MD_MULTU: return MC;
      MD_DIV, MD_DIVU:   return DC;
`ifdef MULDIV_MADD_EN
      MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: return MC;
`endif
      default: return 0;
    endcase
  endfunction

  // Architectural effect of one op on HI/LO, from the arithmetic definitions.
  task automatic model_apply(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0] p;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (o)
      MD_MULT:  begin p = sa * sb; {hi_m, lo_m} = p; end
      MD_MULTU: begin p = ua * ub; {hi_m, lo_m} = p; end
      MD_DIV: if (b != 0) begin
        q = (sa < 0 ? -sa : sa) / (sb < 0 ? -sb : sb);
        if ((sa < 0) != (sb < 0)) q = -q;
        r = sa - q * sb;
        lo_m = q[31:0];
        hi_m = r[31:0];
      end
      MD_DIVU: if (b != 0) begin
        lo_m = 32'(ua / ub);
        hi_m = 32'(ua % ub);
      end
      MD_MTHI: hi_m = a;
      MD_MTLO: lo_m = a;
`ifdef MULDIV_MADD_EN
      MD_MADD:  begin p = {hi_m, lo_m} + 64'(sa * sb); {hi_m, lo_m} = p; end
      MD_MADDU: begin p = {hi_m, lo_m} + 64'(ua * ub); {hi_m, lo_m} = p; end
      MD_MSUB:  begin p = {hi_m, lo_m} - 64'(sa * sb); {hi_m, lo_m} = p; end
      MD_MSUBU: begin p = {hi_m, lo_m} - 64'(ua * ub); {hi_m, lo_m} = p; end
`endif
      default: ;
    endcase
  endtask

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // Issue one op (called #1 after an edge), run it to completion and check busy length and HI/LO.
  task automatic run_op(input string name, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] hi_old, lo_old;
    int n;
    int en;
    hi_old = hi_m;
    lo_old = lo_m;
    en = exp_cycles(o);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(posedge clk); #1;
    start = 1'b0; op = MD_NONE; rs_val = $urandom; rt_val = $urandom;
    model_apply(o, a, b);
    n = 0;
    while (busy && n < 200) begin
      if (n == 0) begin
        checks++;
        if (hi !== hi_old || lo !== lo_old) begin
          errors++;
          $display("FAIL %s hold_during_run: hi=%h lo=%h required hi=%h lo=%h", name, hi, lo, hi_old, lo_old);
        end
      end
      n++;
      @(posedge clk); #1;
    end
    checks++;
    if (n !== en) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d required %0d", name, n, en);
    end
    checks++;
    if (hi !== hi_m || lo !== lo_m) begin
      errors++;
      $display("FAIL %s result: hi=%h lo=%h required hi=%h lo=%h (a=%h b=%h)", name, hi, lo, hi_m, lo_m, a, b);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = MD_NONE; rs_val = '0; rt_val = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    hi_m = '0; lo_m = '0;
    checks++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: busy=%b hi=%h lo=%h required busy=0 hi=0 lo=0", busy, hi, lo);
    end
  endtask

  task automatic test_directed();
    logic [3:0]  t_op [6];
    logic [31:0] t_a  [6];
    logic [31:0] t_b  [6];
    logic [31:0] t_hi [6];
    logic [31:0] t_lo [6];
    t_op = '{MD_MTHI, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_DIV};
    t_a  = '{32'h5555_AAAA, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'h7, 32'h8000_0000};
    t_b  = '{32'h0, 32'h3, 32'hFFFF_FFFF, 32'h2, 32'h0, 32'hFFFF_FFFF};
    t_hi = '{32'h5555_AAAA, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
    t_lo = '{32'h0, 32'hFFFF_FFFA, 32'h0000_0001, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000};
    for (int i = 0; i < 6; i++) begin
      run_op($sformatf("directed%0d", i), t_op[i], t_a[i], t_b[i]);
      checks++;
      if (hi !== t_hi[i] || lo !== t_lo[i]) begin
        errors++;
        $display("FAIL directed%0d const: hi=%h lo=%h required hi=%h lo=%h", i, hi, lo, t_hi[i], t_lo[i]);
      end
    end
  endtask

  task automatic test_mthi_mtlo();
    int busy_hits;
    busy_hits = 0;
    start = 1'b1; op = MD_MTHI; rs_val = 32'h1234_5678; rt_val = '0;
    @(posedge clk); #1;
    if (busy) busy_hits++;
    checks++;
    if (hi !== 32'h1234_5678) begin
      errors++;
      $display("FAIL mthi: hi=%h required 12345678", hi);
    end
    op = MD_MTLO; rs_val = 32'h9;
    @(posedge clk); #1;
    if (busy) busy_hits++;
    start = 1'b0; op = MD_NONE;
    checks++;
    if (lo !== 32'h9 || hi !== 32'h1234_5678) begin
      errors++;
      $display("FAIL mtlo: hi=%h lo=%h required hi=12345678 lo=00000009", hi, lo);
    end
    checks++;
    if (busy_hits !== 0) begin
      errors++;
      $display("FAIL mt_busy: busy seen %0d cycles required 0", busy_hits);
    end
    hi_m = 32'h1234_5678; lo_m = 32'h9;
  endtask

  task automatic test_ignore_while_busy();
    int n;
    int ign0;
    ign0 = ign_seen;
    start = 1'b1; op = MD_DIV; rs_val = 32'd100; rt_val = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; op = MD_NONE;
    n = 0;
    while (busy && n < 200) begin
      start = 1'b0; op = MD_NONE;
      if (n == 2) begin start = 1'b1; op = MD_MTHI; rs_val = 32'hDEAD_BEEF; end
      if (n == 4) begin start = 1'b1; op = MD_MULT; rs_val = 32'd3; rt_val = 32'd3; end
      n++;
      @(posedge clk); #1;
    end
    start = 1'b0; op = MD_NONE;
    checks++;
    if (n !== DC) begin
      errors++;
      $display("FAIL ignore busy_cycles: got %0d required %0d", n, DC);
    end
    checks++;
    if (hi !== 32'd2 || lo !== 32'd14) begin
      errors++;
      $display("FAIL ignore result: hi=%h lo=%h required hi=00000002 lo=0000000e", hi, lo);
    end
    checks++;
    if (ign_seen - ign0 !== 2) begin
      errors++;
      $display("FAIL ignore flag: flagged %0d required 2", ign_seen - ign0);
    end
    repeat (3) @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd2 || lo !== 32'd14) begin
      errors++;
      $display("FAIL ignore after: busy=%b hi=%h lo=%h required busy=0 hi=2 lo=e", busy, hi, lo);
    end
    hi_m = 32'd2; lo_m = 32'd14;
  endtask

  task automatic test_random();
    logic [3:0] tbl [6];
    logic [3:0] o;
    tbl = '{MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO};
    for (int i = 0; i < 30; i++) begin
      o = tbl[$urandom_range(0, 5)];
      run_op($sformatf("rand%0d_op%0d", i, o), o, pick32(), pick32());
    end
  endtask

  task automatic test_reset_mid_op();
    run_op("preload_hi", MD_MTHI, 32'hA5A5_0001, 32'h0);
    start = 1'b1; op = MD_MULT; rs_val = 32'h0001_0003; rt_val = 32'h0002_0005;
    @(posedge clk); #1;
    start = 1'b0; op = MD_NONE;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    hi_m = '0; lo_m = '0;
    checks++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b hi=%h lo=%h required busy=0 hi=0 lo=0", busy, hi, lo);
    end
    repeat (8) @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      errors++;
      $display("FAIL reset_late_write: busy=%b hi=%h lo=%h required busy=0 hi=0 lo=0", busy, hi, lo);
    end
  endtask

`ifdef MULDIV_MADD_EN
  task automatic test_madd();
    logic [3:0] tbl [4];
    logic [3:0] o;
    run_op("madd_pre_hi", MD_MTHI, 32'h0, 32'h0);
    run_op("madd_pre_lo", MD_MTLO, 32'hFFFF_FFFF, 32'h0);
    run_op("maddu_carry", MD_MADDU, 32'h1, 32'h1);
    checks++;
    if (hi !== 32'h1 || lo !== 32'h0) begin
      errors++;
      $display("FAIL maddu_carry const: hi=%h lo=%h required hi=00000001 lo=00000000", hi, lo);
    end
    tbl = '{MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU};
    for (int i = 0; i < 12; i++) begin
      o = tbl[$urandom_range(0, 3)];
      run_op($sformatf("macc%0d_op%0d", i, o), o, pick32(), pick32());
    end
  endtask
`endif

  initial begin
    reset = 1'b1; start = 1'b0; op = MD_NONE; rs_val = '0; rt_val = '0;
    hi_m = '0; lo_m = '0;
    @(posedge clk); #1;
    test_reset();
    test_directed();
    test_mthi_mtlo();
    test_ignore_while_busy();
    test_random();
`ifdef MULDIV_MADD_EN
    test_madd();
`endif
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
